// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller: decodes one memory request, drives a handshaked
// single-ported data bus, steers byte lanes, extends load data and detects bus timeouts.
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    ld_off;
  logic [2:0]    ld_f3;
  logic          ld_store;

  logic          legal;
  logic          misaligned;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;

  assign stall = ((state == IDLE) && req_valid) || (state == ACCESS);

  // Request decode: encoding legality, alignment and store lane steering.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = req_wdata;
    if (req_is_store)
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
              (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    if (req_is_store) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_next    = 4'b0001 << req_addr[1:0];
          wdata_next = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{req_wdata[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (ld_off)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    case (ld_f3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'h000000, byte_sel};
      3'b101:  load_data = {16'h0000, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ld_off    <= 2'd0;
      ld_f3     <= 3'd0;
      ld_store  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'h0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (legal && !misaligned) begin
              state     <= ACCESS;
              cnt       <= '0;
              ld_off    <= req_addr[1:0];
              ld_f3     <= req_funct3;
              ld_store  <= req_is_store;
              mem_req   <= 1'b1;
              mem_we    <= req_is_store;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end
          end
        end
        ACCESS: begin
          // Priority: bus error, then ack, then timeout.
          if (mem_err || mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= mem_err;
            rsp_rdata <= (mem_err || ld_store) ? 32'h0 : load_data;
          end else begin
            cnt <= cnt + CW'(1);
            if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
              state     <= RESP;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end
          end
        end
        RESP: begin
          state   <= IDLE;
          rsp_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl: loads, stores, lane steering, error paths,
// wait states, timeout (second instance with a short timeout) and reset mid-access.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid4;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_ack, mem_err;
  logic [31:0] mem_rdata;

  logic        stall, rsp_valid, rsp_err, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        stall4, rsp_valid4, rsp_err4, mem_req4, mem_we4;
  logic [31:0] rsp_rdata4, mem_addr4, mem_wdata4;
  logic [3:0]  mem_be4;

  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall4), .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4),
    .mem_req(mem_req4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_be(mem_be4), .mem_ack(1'b0), .mem_rdata(32'h0), .mem_err(1'b0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Issues one request, answers on the bus after `waits` wait cycles, and records what was seen.
  task automatic applyStimulus(
    input  logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
    input  int waits, input logic [31:0] rd, input logic give_ack, input logic give_err,
    output int lat, output logic [31:0] rdata, output logic rerr,
    output logic saw_req, output logic [31:0] b_addr, output logic [31:0] b_wdata,
    output logic [3:0] b_be, output logic b_we, output logic stable,
    output logic stall_ok, output logic one_pulse);
    int acc;
    @(posedge clk); #1;
    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    lat = -1; rdata = 32'hx; rerr = 1'bx; saw_req = 1'b0; stable = 1'b1; stall_ok = 1'b1;
    b_addr = 32'h0; b_wdata = 32'h0; b_be = 4'h0; b_we = 1'b0; acc = 0; one_pulse = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = cyc; rdata = rsp_rdata; rerr = rsp_err;
        if (stall !== 1'b0 || mem_req !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (mem_req) begin
        if (!saw_req) begin
          b_addr = mem_addr; b_wdata = mem_wdata; b_be = mem_be; b_we = mem_we;
        end else if (mem_addr !== b_addr || mem_wdata !== b_wdata || mem_be !== b_be ||
                     mem_we !== b_we) begin
          stable = 1'b0;
        end
        saw_req = 1'b1;
        acc++;
      end
      mem_rdata = rd;
      mem_ack = mem_req && give_ack && (acc == waits + 1);
      mem_err = mem_req && give_err && (acc == waits + 1);
      @(posedge clk); #1;
      req_valid = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
    end
    req_valid = 1'b0;
    @(negedge clk);
    one_pulse = (lat >= 0) && (rsp_valid === 1'b0);
  endtask

  int          lat, n, pulses;
  logic [31:0] rdata, b_addr, b_wdata;
  logic [3:0]  b_be;
  logic        rerr, saw_req, b_we, stable, stall_ok, one_pulse;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_valid4 = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
    #12;
    checkOutput("reset_stall", {31'b0, stall}, 32'h0);
    checkOutput("reset_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("reset_mem_be", {28'b0, mem_be}, 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    #8 rst_n = 1'b1;

    // LW, immediate ack
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("lw_latency", lat, 2);
    checkOutput("lw_rdata", rdata, 32'hDEADBEEF);
    checkOutput("lw_err", {31'b0, rerr}, 32'h0);
    checkOutput("lw_be", {28'b0, b_be}, 32'hF);
    checkOutput("lw_we", {31'b0, b_we}, 32'h0);
    checkOutput("lw_addr", b_addr, 32'h100);
    checkOutput("lw_stall", {31'b0, stall_ok}, 32'h1);
    checkOutput("lw_pulse", {31'b0, one_pulse}, 32'h1);

    applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF1234, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("lb_rdata", rdata, 32'hFFFFFF80);
    checkOutput("lb_addr", b_addr, 32'h100);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF1234, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("lbu_rdata", rdata, 32'h00000080);
    applyStimulus(1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF1234, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("lh_hi_rdata", rdata, 32'hFFFF80FF);
    applyStimulus(1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80FF1234, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("lhu_hi_rdata", rdata, 32'h000080FF);
    applyStimulus(1'b0, 3'b001, 32'h100, 32'h0, 0, 32'h80FF9234, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("lh_lo_rdata", rdata, 32'hFFFF9234);
    applyStimulus(1'b0, 3'b000, 32'h101, 32'h0, 0, 32'h80FF1234, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("lb_b1_rdata", rdata, 32'h00000012);

    // Stores
    applyStimulus(1'b1, 3'b000, 32'h202, 32'h55, 0, 32'hFFFFFFFF, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("sb_we", {31'b0, b_we}, 32'h1);
    checkOutput("sb_be", {28'b0, b_be}, 32'h4);
    checkOutput("sb_wdata", b_wdata, 32'h55555555);
    checkOutput("sb_addr", b_addr, 32'h200);
    checkOutput("sb_rdata", rdata, 32'h0);
    applyStimulus(1'b1, 3'b001, 32'h202, 32'hBEEF, 0, 32'h0, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("sh_be", {28'b0, b_be}, 32'hC);
    checkOutput("sh_wdata", b_wdata, 32'hBEEFBEEF);
    applyStimulus(1'b1, 3'b010, 32'h204, 32'h12345678, 0, 32'h0, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("sw_be", {28'b0, b_be}, 32'hF);
    checkOutput("sw_wdata", b_wdata, 32'h12345678);
    checkOutput("sw_addr", b_addr, 32'h204);

    // Misaligned and illegal requests never reach the bus
    applyStimulus(1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("lw_mis_latency", lat, 1);
    checkOutput("lw_mis_err", {31'b0, rerr}, 32'h1);
    checkOutput("lw_mis_noreq", {31'b0, saw_req}, 32'h0);
    checkOutput("lw_mis_stall", {31'b0, stall_ok}, 32'h1);
    applyStimulus(1'b1, 3'b100, 32'h200, 32'h0, 0, 32'h0, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("st_ill_latency", lat, 1);
    checkOutput("st_ill_err", {31'b0, rerr}, 32'h1);
    checkOutput("st_ill_noreq", {31'b0, saw_req}, 32'h0);
    applyStimulus(1'b0, 3'b001, 32'h103, 32'h0, 0, 32'h0, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("lh_mis_err", {31'b0, rerr}, 32'h1);
    checkOutput("lh_mis_noreq", {31'b0, saw_req}, 32'h0);
    applyStimulus(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("ld_ill_err", {31'b0, rerr}, 32'h1);
    checkOutput("ld_ill_noreq", {31'b0, saw_req}, 32'h0);

    // Wait states and bus errors
    applyStimulus(1'b0, 3'b010, 32'h300, 32'h0, 5, 32'hA5A5_0F0F, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("wait5_latency", lat, 7);
    checkOutput("wait5_stable", {31'b0, stable}, 32'h1);
    checkOutput("wait5_rdata", rdata, 32'hA5A50F0F);
    checkOutput("wait5_stall", {31'b0, stall_ok}, 32'h1);
    applyStimulus(1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h11112222, 1'b1, 1'b1,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("ackerr_err", {31'b0, rerr}, 32'h1);
    checkOutput("ackerr_rdata", rdata, 32'h0);
    applyStimulus(1'b1, 3'b010, 32'h308, 32'h1, 2, 32'h0, 1'b0, 1'b1,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("err_latency", lat, 4);
    checkOutput("err_err", {31'b0, rerr}, 32'h1);

    // Timeout on the short-timeout instance
    @(posedge clk); #1;
    req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500; req_valid4 = 1'b1;
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req4) n++;
      else break;
    end
    checkOutput("tmo_req_cycles", n, 4);
    checkOutput("tmo_rsp_valid", {31'b0, rsp_valid4}, 32'h1);
    checkOutput("tmo_rsp_err", {31'b0, rsp_err4}, 32'h1);

    // Reset in the middle of an access
    @(posedge clk); #1;
    req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_pre_req", {31'b0, mem_req}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_req", {31'b0, mem_req}, 32'h0);
    checkOutput("rst_async_stall", {31'b0, stall}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    checkOutput("rst_no_rsp", pulses, 0);
    applyStimulus(1'b0, 3'b010, 32'h404, 32'h0, 1, 32'hCAFEF00D, 1'b1, 1'b0,
                  lat, rdata, rerr, saw_req, b_addr, b_wdata, b_be, b_we, stable, stall_ok, one_pulse);
    checkOutput("post_rst_latency", lat, 3);
    checkOutput("post_rst_rdata", rdata, 32'hCAFEF00D);
    checkOutput("post_rst_err", {31'b0, rerr}, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
